// File: rtl/pipemem_io_stage.sv
// pipemem_io_stage: memory stage with a wait-stated data RAM,
// memory-mapped output registers and synchronised input ports.
module pipemem_io_stage #(
    parameter int ADDR_W      = 5,
    parameter int N_OUT       = 6,
    parameter int N_IN        = 2,
    parameter int IN_W        = 4,
    parameter int WAIT_CYCLES = 1,
    parameter int IO_BIT      = 7
) (
    input  logic                 clock,
    input  logic                 clrn,
    input  logic                 mwmem,
    input  logic                 mrmem,
    input  logic [1:0]           msize,
    input  logic                 msign,
    input  logic [31:0]          malu,
    input  logic [31:0]          mb,
    input  logic [4:0]           mrn,
    input  logic                 wm2reg,
    input  logic [4:0]           wrn,
    input  logic [31:0]          wmo,
    input  logic [N_IN*IN_W-1:0] in_port,
    output logic [31:0]          mmo,
    output logic                 mem_stall,
    output logic                 misalign,
    output logic [N_OUT*32-1:0]  out_port
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;
    localparam logic [3:0] CNT_INIT =
        (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    logic [31:0] ram [2**ADDR_W];

    logic [0:0]           state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [N_IN*IN_W-1:0] sync1_q, sync1_d;
    logic [N_IN*IN_W-1:0] sync2_q, sync2_d;
    logic [N_OUT*32-1:0]  out_q, out_d;

    logic              access, io, ram_acc;
    logic              ram_we, io_we;
    logic [31:0]       datain, wdata, raw, lane;
    logic [3:0]        be;
    logic [ADDR_W-1:0] widx;
    logic [2:0]        iidx;
    logic              unused_ok;

    // only a subset of the address bits is decoded
    assign unused_ok = ^malu;

    assign access = mwmem | mrmem;
    assign io     = malu[IO_BIT];
    assign widx   = malu[ADDR_W+1:2];
    assign iidx   = malu[4:2];

    always_comb begin
        datain = mb;
        if (wm2reg && wrn == mrn && wrn != 5'd0) datain = wmo;
    end

    always_comb begin
        misalign = 1'b0;
        if (access) begin
            if (msize == 2'b01) misalign = malu[0];
            else if (msize[1]) misalign = (malu[1:0] != 2'b00);
        end
    end

    assign ram_acc = access && !io && !misalign;
    assign io_we   = mwmem && io && !misalign;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_stall = 1'b0;
        ram_we    = 1'b0;
        if (WAIT_CYCLES == 0) begin
            ram_we = ram_acc && mwmem;
        end else if (state_q == IDLE) begin
            if (ram_acc) begin
                mem_stall = 1'b1;
                state_d   = BUSY;
                cnt_d     = CNT_INIT;
            end
        end else if (cnt_q != 4'd0) begin
            mem_stall = 1'b1;
            cnt_d     = cnt_q - 4'd1;
        end else begin
            ram_we  = ram_acc && mwmem;
            state_d = IDLE;
        end
        if (!clrn) begin
            mem_stall = 1'b0;
            ram_we    = 1'b0;
        end
    end

    always_comb begin
        be    = 4'b1111;
        wdata = datain;
        case (msize)
            2'b00: begin
                be    = 4'b0001 << malu[1:0];
                wdata = {4{datain[7:0]}};
            end
            2'b01: begin
                be    = malu[1] ? 4'b1100 : 4'b0011;
                wdata = {2{datain[15:0]}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) ram[widx][i*8 +: 8] <= wdata[i*8 +: 8];
        end
    end

    always_comb begin
        raw = ram[widx];
        if (io) begin
            raw = '0;
            for (int k = 0; k < N_IN; k++)
                if (iidx == 3'(k))
                    raw[IN_W-1:0] = sync2_q[k*IN_W +: IN_W];
        end
    end

    always_comb begin
        lane = raw;
        case (msize)
            2'b00: begin
                lane = {24'd0, raw[{malu[1:0], 3'b000} +: 8]};
                if (msign) lane[31:8] = {24{lane[7]}};
            end
            2'b01: begin
                lane = {16'd0, malu[1] ? raw[31:16] : raw[15:0]};
                if (msign) lane[31:16] = {16{lane[15]}};
            end
            default: ;
        endcase
        mmo = misalign ? 32'd0 : lane;
    end

    always_comb begin
        out_d = out_q;
        for (int k = 0; k < N_OUT; k++)
            if (io_we && iidx == 3'(k)) out_d[k*32 +: 32] = datain;
        sync1_d = in_port;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            out_q   <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign out_port = out_q;

endmodule

// File: tb/tb_pipemem_io_stage.sv
// tb_pipemem_io_stage: directed and random checks of the M stage
// against a byte-level memory/IO reference model.
module tb_pipemem_io_stage;
    localparam int AW  = 5;
    localparam int NO  = 6;
    localparam int NI  = 2;
    localparam int IW  = 4;
    localparam int W   = 1;
    localparam int WB  = 3;
    localparam int IPW = NI * IW;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic           clrn, b_rstn;
    logic           mwmem, mrmem, b_wr, b_rd;
    logic [1:0]     msize;
    logic           msign, wm2reg;
    logic [31:0]    malu, mb, wmo;
    logic [4:0]     mrn, wrn;
    logic [IPW-1:0] in_port;
    logic [31:0]    mmo, b_mmo;
    logic           mem_stall, b_stall, misalign, b_mis;
    logic [NO*32-1:0] out_port, b_out;

    int checks = 0;
    int failures = 0;

    byte unsigned mem_m [128];
    logic [31:0]  out_m [NO];
    logic [31:0]  g, a, bv, wv;
    logic [1:0]   sz;
    int           op;

    pipemem_io_stage #(
        .ADDR_W(AW), .N_OUT(NO), .N_IN(NI), .IN_W(IW),
        .WAIT_CYCLES(W), .IO_BIT(7)
    ) u_a (
        .clock(clock), .clrn(clrn), .mwmem(mwmem), .mrmem(mrmem),
        .msize(msize), .msign(msign), .malu(malu), .mb(mb),
        .mrn(mrn), .wm2reg(wm2reg), .wrn(wrn), .wmo(wmo),
        .in_port(in_port), .mmo(mmo), .mem_stall(mem_stall),
        .misalign(misalign), .out_port(out_port)
    );

    pipemem_io_stage #(
        .ADDR_W(AW), .N_OUT(NO), .N_IN(NI), .IN_W(IW),
        .WAIT_CYCLES(WB), .IO_BIT(7)
    ) u_b (
        .clock(clock), .clrn(b_rstn), .mwmem(b_wr), .mrmem(b_rd),
        .msize(msize), .msign(msign), .malu(malu), .mb(mb),
        .mrn(mrn), .wm2reg(wm2reg), .wrn(wrn), .wmo(wmo),
        .in_port(in_port), .mmo(b_mmo), .mem_stall(b_stall),
        .misalign(b_mis), .out_port(b_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] load_m(input logic [1:0] s,
        input bit sg, input logic [31:0] ad);
        int          n;
        int          idx;
        logic [31:0] v;
        logic [31:0] word;
        byte unsigned by;
        n = nbytes(s);
        v = 0;
        word = 0;
        if (ad % n != 0) return 32'd0;
        if (ad[7]) begin
            idx = int'((ad / 4) % 8);
            if (idx < NI) word = 32'((in_port >> (idx * IW)) & ((1 << IW) - 1));
        end
        for (int i = 0; i < n; i++) begin
            if (ad[7]) by = 8'(word >> (8 * (int'(ad % 4) + i)));
            else by = mem_m[int'(ad % 128) + i];
            v = v | (32'(by) << (8 * i));
        end
        if (sg && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
        return v;
    endfunction

    task automatic store_m(input logic [1:0] s, input logic [31:0] ad,
                           input logic [31:0] d);
        int n;
        int idx;
        n = nbytes(s);
        if (ad % n != 0) return;
        if (ad[7]) begin
            idx = int'((ad / 4) % 8);
            if (idx < NO) out_m[idx] = d;
        end else begin
            for (int i = 0; i < n; i++)
                mem_m[int'(ad % 128) + i] = 8'(d >> (8 * i));
        end
    endtask

    task automatic do_acc(input bit wr, input bit rd, input logic [1:0] s,
        input bit sg, input logic [31:0] ad, input logic [31:0] b,
        input bit fw, input logic [4:0] rw, input logic [4:0] rm,
        input logic [31:0] wd, output logic [31:0] got);
        logic [31:0] exp_ld, din;
        bit mis, ram;
        int len;
        @(negedge clock);
        mwmem = wr; mrmem = rd; msize = s; msign = sg; malu = ad;
        mb = b; wm2reg = fw; wrn = rw; mrn = rm; wmo = wd;
        mis = (wr || rd) && (ad % nbytes(s) != 0);
        ram = (wr || rd) && !mis && !ad[7];
        len = ram ? W + 1 : 1;
        exp_ld = load_m(s, sg, ad);
        din = (fw && rw == rm && rw != 0) ? wd : b;
        got = 'x;
        for (int c = 0; c < len; c++) begin
            if (c > 0) @(negedge clock);
            #2;
            chk("stall", 32'(mem_stall), 32'(c < len - 1));
            chk("misalign", 32'(misalign), 32'(mis));
            if (c == len - 1) begin
                got = mmo;
                if (rd) chk("mmo", mmo, exp_ld);
            end
        end
        @(posedge clock);
        #1;
        mwmem = 1'b0;
        mrmem = 1'b0;
        if (wr) store_m(s, ad, din);
        for (int k = 0; k < NO; k++)
            chk("out_port", out_port[k*32 +: 32], out_m[k]);
    endtask

    task automatic b_acc(input bit wr, input logic [31:0] ad,
                         input logic [31:0] d, output logic [31:0] got);
        @(negedge clock);
        b_wr = wr; b_rd = !wr; msize = 2'd2; msign = 1'b0;
        malu = ad; mb = d; wm2reg = 1'b0;
        got = 'x;
        for (int c = 0; c <= WB; c++) begin
            if (c > 0) @(negedge clock);
            #2;
            chk("b_stall", 32'(b_stall), 32'(c < WB));
            if (c == WB) got = b_mmo;
        end
        @(posedge clock);
        #1;
        b_wr = 1'b0;
        b_rd = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        clrn = 0; b_rstn = 0;
        mwmem = 0; mrmem = 0; b_wr = 0; b_rd = 0;
        msize = 2'd2; msign = 0; malu = 32'h80; mb = 0;
        mrn = 0; wrn = 0; wm2reg = 0; wmo = 0; in_port = '0;
        for (int k = 0; k < NO; k++) out_m[k] = 0;
        #2;
        chk("rst_stall", 32'(mem_stall), 32'd0);
        chk("rst_mis", 32'(misalign), 32'd0);
        chk("rst_mmo_io", mmo, 32'd0);
        for (int k = 0; k < NO; k++)
            chk("rst_out", out_port[k*32 +: 32], 32'd0);
        @(negedge clock);
        clrn = 1; b_rstn = 1;

        for (int i = 0; i < 32; i++)
            do_acc(1, 0, 2'd2, 0, 32'(i * 4), $urandom, 0, 0, 0, 0, g);

        do_acc(1, 0, 2'd2, 0, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, g);
        do_acc(0, 1, 2'd2, 0, 32'h10, 0, 0, 0, 0, 0, g);
        chk("tp_word", g, 32'hDEADBEEF);
        do_acc(0, 1, 2'd0, 1, 32'h13, 0, 0, 0, 0, 0, g);
        chk("tp_byte_s", g, 32'hFFFFFFDE);
        do_acc(0, 1, 2'd0, 0, 32'h13, 0, 0, 0, 0, 0, g);
        chk("tp_byte_u", g, 32'h000000DE);
        do_acc(1, 0, 2'd1, 0, 32'h12, 32'h00001234, 0, 0, 0, 0, g);
        do_acc(0, 1, 2'd2, 0, 32'h10, 0, 0, 0, 0, 0, g);
        chk("tp_half_st", g, 32'h1234BEEF);

        do_acc(1, 0, 2'd2, 0, 32'h20, 0, 1, 5'd5, 5'd5, 32'hA5A5A5A5, g);
        do_acc(0, 1, 2'd2, 0, 32'h20, 0, 0, 0, 0, 0, g);
        chk("tp_fwd", g, 32'hA5A5A5A5);
        do_acc(1, 0, 2'd2, 0, 32'h20, 0, 1, 5'd0, 5'd0, 32'hA5A5A5A5, g);
        do_acc(0, 1, 2'd2, 0, 32'h20, 0, 0, 0, 0, 0, g);
        chk("tp_fwd_r0", g, 32'h0);

        do_acc(1, 0, 2'd2, 0, 32'h84, 32'h55, 0, 0, 0, 0, g);
        chk("tp_io_out1", out_port[63:32], 32'h55);
        do_acc(1, 0, 2'd2, 0, 32'h9C, 32'h12345678, 0, 0, 0, 0, g);

        @(negedge clock);
        in_port = IPW'(8'hA0);
        mrmem = 1; mwmem = 0; msize = 2'd2; msign = 0; malu = 32'h84;
        #2 chk("in_sync0", mmo, 32'h0);
        @(posedge clock);
        #2 chk("in_sync1", mmo, 32'h0);
        @(posedge clock);
        #2 chk("in_sync2", mmo, 32'hA);
        mrmem = 0;

        do_acc(1, 0, 2'd2, 0, 32'h11, 32'hFFFFFFFF, 0, 0, 0, 0, g);
        chk("tp_mis_mmo", g, 32'h0);
        do_acc(0, 1, 2'd2, 0, 32'h10, 0, 0, 0, 0, 0, g);
        chk("tp_mis_keep", g, 32'h1234BEEF);

        @(negedge clock);
        b_wr = 1; msize = 2'd2; malu = 32'h80; mb = 32'h77; wm2reg = 0;
        @(posedge clock);
        #1 b_wr = 0;
        chk("b_io", b_out[31:0], 32'h77);
        b_acc(1, 32'h40, 32'h11223344, g);
        @(negedge clock);
        b_wr = 1; malu = 32'h40; mb = 32'hCAFEF00D;
        @(posedge clock);
        @(posedge clock);
        #2 b_rstn = 0; b_wr = 0;
        #1 chk("b_rst_stall", 32'(b_stall), 32'd0);
        for (int k = 0; k < NO; k++)
            chk("b_rst_out", b_out[k*32 +: 32], 32'd0);
        @(negedge clock);
        b_rstn = 1;
        b_acc(0, 32'h40, 0, g);
        chk("b_rst_keep", g, 32'h11223344);

        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 9) == 0) begin
                @(negedge clock);
                in_port = IPW'($urandom);
                repeat (2) @(posedge clock);
            end
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            sz = 2'($urandom_range(0, 3));
            op = $urandom_range(0, 3);
            bv = $urandom;
            wv = $urandom;
            do_acc(op == 1 || op == 2, op != 1, sz, 1'($urandom_range(0, 1)),
                   a, bv, 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), wv, g);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipemem_io_stage.md
Name: pipemem_io_stage

Overview:
- Parametrised memory (M) stage for the pipelined CPU.
- Internal word-addressed data RAM with byte/halfword/word access, sign or zero extension, and programmable wait states that stall the pipeline.
- Memory-mapped IO: N_OUT output registers and N_IN synchronised input ports, selected by address bit IO_BIT.
- Store data is forwarded from the WB stage when WB is loading the register being stored.

Parameters:
- ADDR_W, 5: data RAM word-address bits (2**ADDR_W words).
- N_OUT, 6: number of 32-bit output port registers (1..8).
- N_IN, 2: number of input ports (1..8).
- IN_W, 4: width of each input port (1..32).
- WAIT_CYCLES, 1: extra stall cycles per data-RAM access (0..15).
- IO_BIT, 7: malu bit selecting IO space (1) or RAM (0).

Ports:
- clock  in  1  stage clock; all state updates on rising edge.
- clrn  in  1  asynchronous active-low reset.
- mwmem  in  1  store in M stage.
- mrmem  in  1  load in M stage.
- msize  in  2  00 byte, 01 half, 10 word; 11 treated as word.
- msign  in  1  1 = sign-extend sub-word loads.
- malu  in  32  byte address.
- mb  in  32  store data from register file.
- mrn  in  5  destination/source register number in M.
- wm2reg  in  1  WB instruction is a load.
- wrn  in  5  WB destination register.
- wmo  in  32  WB load data.
- in_port  in  N_IN*IN_W  input ports, port k at [k*IN_W +: IN_W].
- mmo  out  32  load result.
- mem_stall  out  1  hold IF/ID/EX/M, bubble WB.
- misalign  out  1  current access misaligned.
- out_port  out  N_OUT*32  output registers, port k at [k*32 +: 32].

Behaviour:
- Forwarding: datain = wmo when wm2reg && wrn==mrn && wrn!=0, else mb.
- Space decode: io = malu[IO_BIT]. RAM word index = malu[ADDR_W+1:2]. IO index = malu[4:2].
- Misalign: asserted when the access (mwmem|mrmem) is a half access with malu[0]=1, or a word access with malu[1:0]!=0. Applies to RAM and IO. A misaligned access:
  - suppresses the write,
  - drives mmo=0,
  - never stalls.
  - misalign is combinational and 0 when there is no access.
- RAM loads: byte/half lanes are selected by malu[1:0] (little-endian) and extended per msign. Read is combinational from the array.
- RAM stores:
  - The byte enable writes only the addressed lanes.
  - Store data is replicated from the low lane(s) of datain.
- RAM timing (FSM IDLE/BUSY, counter cnt of 4 bits):
  - WAIT_CYCLES=0: no stall. The write commits at the end of the access cycle.
  - IDLE with an aligned RAM access: mem_stall=1, next state BUSY, cnt<=WAIT_CYCLES-1.
  - BUSY with cnt!=0: mem_stall=1, cnt decrements.
  - BUSY with cnt==0: mem_stall=0. A store commits at this edge; mmo is valid during this cycle. Next state IDLE.
  - Total access length is WAIT_CYCLES+1 cycles. Each store is written exactly once.
  - Inputs are held stable by the pipeline while mem_stall=1.
  - Back-to-back RAM accesses each pay the full wait.
- IO accesses: zero wait. mem_stall stays 0 and the FSM is unaffected.
- IO writes: full 32-bit datain to out_port[index] at the clock edge, regardless of msize. Index >= N_OUT is ignored.
- IO reads:
  - Index < N_IN returns the synchronised port, zero-extended, with msize/msign extension applied.
  - Index >= N_IN reads 0.
- Input synchroniser: two flops per port. An in_port change is visible on mmo after 2 rising edges.
- Simultaneous mwmem and mrmem: treated as a store; mmo still shows read data.
- Reset (asynchronous, clrn=0):
  - out_port = 0, synchronisers = 0, FSM = IDLE, cnt = 0, mem_stall = 0.
  - Reset mid-access aborts it with no RAM write.
  - RAM contents are not reset.

Test Plan:
- Word store/load, WAIT_CYCLES=1: store 0xDEADBEEF at 0x10 -> mem_stall high for 1 cycle, write on the 2nd edge. Load 0x10 -> mmo=0xDEADBEEF in the 2nd cycle. mem_stall sequence 1,0 for each access.
- Sub-word access: load byte at 0x13 with msign=1 -> 0xFFFFFFDE; with msign=0 -> 0x000000DE. Half-store 0x1234 at 0x12, then word load at 0x10 -> 0x1234BEEF.
- Forwarding: wm2reg=1, wrn=mrn=5, wmo=0xA5A5A5A5, mb=0 store to 0x20 -> RAM reads 0xA5A5A5A5. Repeat with wrn=mrn=0 -> 0x00000000.
- IO: store 0x55 to 0x84 -> out_port[1]=0x55 next edge, no stall. Store to 0x9C with N_OUT=6 -> all ports unchanged. Drive in_port[1]=4'hA, load 0x84 -> mmo=0xA after 2 edges, 0 before.
- Misalign: word store to 0x11 -> misalign=1, no stall, RAM at 0x10 unchanged, mmo=0.
- Reset during BUSY with WAIT_CYCLES=3 -> FSM IDLE, mem_stall=0, target word unchanged, out_port all 0.
